mem_arbiter3: RTL and testbench
===============================

MEM_ARBITER3 -- requirements
Module: mem_arbiter3

Interface
REQ-001 Parameter TIMEOUT, default 16, sets the maximum number of cycles mem_valid may stay high without mem_ready; legal range 1..255.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 reset  input  1  Synchronous, active-high reset.
REQ-004 req  input  3  Per-requester request; bit i is requester i (0 = instr fetch, 1 = data, 2 = debug).
REQ-005 gnt  output  3  One-hot grant, registered; all zeros when idle.
REQ-006 sel  output  2  Registered select for the shared-port 3:1 mux: 2'b00/01/10 = requester 0/1/2; 2'b11 = idle (mux outputs zero).
REQ-007 mem_valid  output  1  Transaction valid to the shared memory port.
REQ-008 mem_ready  input  1  Memory completion; the handshake completes when mem_valid and mem_ready are both high.
REQ-009 done  output  3  One-cycle completion pulse per requester.
REQ-010 err  output  1  One-cycle timeout-abort pulse.

Function
REQ-011 The FSM SHALL have two states: IDLE and BUSY.
REQ-012 The block SHALL hold a 2-bit last-grant pointer `last`, with values 0..2.
REQ-013 The block SHALL hold a wait counter `wcnt`, 8 bits wide.
REQ-014 IDLE: when req != 0 at a clock edge, the block SHALL grant the first asserted requester in order (last+1)%3, (last+2)%3, last.
REQ-015 On that grant edge the block SHALL enter BUSY, load gnt/sel for the chosen requester, and clear wcnt.
REQ-016 IDLE: when req == 0, the block SHALL stay in IDLE with gnt=0 and sel=2'b11.
REQ-017 mem_valid SHALL equal (state == BUSY); it SHALL never be high in IDLE.
REQ-018 In BUSY, gnt and sel SHALL stay constant until BUSY exits.
REQ-019 In BUSY, changes on req SHALL be ignored.
REQ-020 A requester that drops req mid-transaction SHALL NOT abort that transaction.
REQ-021 done[i] SHALL be combinational: BUSY & gnt[i] & (mem_ready | tmo), where tmo = (wcnt == TIMEOUT-1).
REQ-022 done SHALL be asserted in the same cycle as the completing handshake or abort.
REQ-023 err SHALL be combinational: BUSY & tmo & !mem_ready.
REQ-024 If mem_ready and tmo occur in the same cycle, mem_ready SHALL win: done pulses and err stays 0.
REQ-025 BUSY exit: on an edge where mem_ready or tmo holds, the FSM SHALL go to IDLE, gnt SHALL become 0, sel SHALL become 2'b11, and last SHALL load the granted index.
REQ-026 Otherwise wcnt SHALL increment by 1.
REQ-027 Consequence: mem_valid SHALL stay high at most TIMEOUT consecutive cycles.
REQ-028 Minimum spacing SHALL be one IDLE cycle between transactions, i.e. at most one grant per 2 cycles.
REQ-029 A requester SHALL be granted within 3 transactions of asserting req (round-robin fairness).
REQ-030 Requesters SHALL drop req in the cycle after done, or else be re-arbitrated as a new request in the IDLE cycle.

Reset
REQ-031 On reset the block SHALL set: state=IDLE, gnt=3'b000, sel=2'b11, mem_valid=0, wcnt=0, last=2 (requester 0 wins first).
REQ-032 On reset, done and err SHALL be 0.
REQ-033 Reset SHALL override everything, including mid-BUSY.
REQ-034 A transaction in flight at reset SHALL be dropped with no done and no err.

Verification
REQ-035 Reset with req=3'b111 held -> cycle after reset release: gnt=000, sel=11, mem_valid=0; next cycle: gnt=001, sel=00, mem_valid=1.
REQ-036 req=010 only, mem_ready high in the 2nd BUSY cycle -> gnt=010, sel=01 for 2 cycles; done=010 in the 2nd; then IDLE, sel=11.
REQ-037 req=111 held, mem_ready tied 1 -> grant sequence 001,010,100,001 with alternating IDLE cycles; done pulses in the same order.
REQ-038 TIMEOUT=4, req=100, mem_ready=0 -> mem_valid high exactly 4 cycles; err=1 and done=100 on the 4th cycle; then IDLE, last=2.
REQ-039 TIMEOUT=4, mem_ready rises on the 4th BUSY cycle -> done=100, err=0.
REQ-040 Reset asserted during BUSY with gnt=010 -> next cycle IDLE, gnt=0, no done; with req=011, the next grant is 001.

Source files
------------

// File: rtl/mem_arbiter3.sv
// mem_arbiter3: round-robin arbiter for three requesters sharing one memory
// port. It runs one transaction at a time. A transaction ends on a handshake
// or when it has waited too long for mem_ready.
module mem_arbiter3 #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       mem_valid,
    input  logic       mem_ready,
    output logic [2:0] done,
    output logic       err
);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_BUSY = 1'b1;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0] SEL_IDLE = 2'b11;

    logic [0:0] state;
    logic [1:0] last;
    logic [7:0] wcnt;
    logic [1:0] pick_idx;
    logic       busy;
    logic       tmo;
    logic       finish;

    assign busy      = (state == STATE_BUSY);
    assign tmo       = (wcnt == TMO_LAST);
    assign finish    = busy && (mem_ready || tmo);
    assign mem_valid = busy;

    // A transaction that is dropped by reset produces no completion and no abort.
    assign done = (finish && !reset) ? gnt : '0;
    assign err  = busy && tmo && !mem_ready && !reset;

    // Pick the next requester, searching from the one after the last winner.
    always_comb begin
        pick_idx = '0;
        case (last)
            2'd0:    pick_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    pick_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: pick_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    // FSM, grant/select registers, last-winner pointer and the wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STATE_IDLE;
            gnt   <= '0;
            sel   <= SEL_IDLE;
            wcnt  <= '0;
            last  <= 2'd2;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (req != 3'b000) begin
                        state <= STATE_BUSY;
                        gnt   <= 3'b001 << pick_idx;
                        sel   <= pick_idx;
                        wcnt  <= '0;
                    end else begin
                        gnt <= '0;
                        sel <= SEL_IDLE;
                    end
                end
                default: begin
                    if (mem_ready || tmo) begin
                        state <= STATE_IDLE;
                        gnt   <= '0;
                        sel   <= SEL_IDLE;
                        // sel holds the granted index for the whole transaction.
                        last  <= sel;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter3.sv
// tb_mem_arbiter3: scoreboard bench for mem_arbiter3 (TIMEOUT = 4).
module tb_mem_arbiter3;

    logic       clk;
    logic       reset;
    logic [2:0] req;
    logic       mem_ready;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       mem_valid;
    logic [2:0] done;
    logic       err;

    int unsigned n_checks;
    int unsigned n_fail;

    typedef struct packed {
        logic [2:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic [2:0] done;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    mem_arbiter3 #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .done      (done),
        .err       (err)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic cyc(input logic rst, input logic [2:0] r, input logic rdy,
                       input logic [2:0] eg, input logic [1:0] es, input logic ev,
                       input logic [2:0] ed, input logic ee);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        req       = r;
        mem_ready = rdy;
        e.gnt   = eg;
        e.sel   = es;
        e.valid = ev;
        e.done  = ed;
        e.err   = ee;
        exp_q.push_back(e);
    endtask

    // Compare DUT outputs against the queued expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("gnt",       8'(gnt),       8'(e.gnt));
                check_eq("sel",       8'(sel),       8'(e.sel));
                check_eq("mem_valid", 8'(mem_valid), 8'(e.valid));
                check_eq("done",      8'(done),      8'(e.done));
                check_eq("err",       8'(err),       8'(e.err));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        req       = 3'b000;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Reset with all requests held, then release: requester 0 wins first.
        cyc(1, 3'b111, 0, 3'b000, 2'b11, 0, 3'b000, 0);
        cyc(0, 3'b111, 0, 3'b000, 2'b11, 0, 3'b000, 0);
        // Round robin with mem_ready tied high.
        cyc(0, 3'b111, 1, 3'b001, 2'b00, 1, 3'b001, 0);
        cyc(0, 3'b111, 1, 3'b000, 2'b11, 0, 3'b000, 0);
        cyc(0, 3'b111, 1, 3'b010, 2'b01, 1, 3'b010, 0);
        cyc(0, 3'b111, 1, 3'b000, 2'b11, 0, 3'b000, 0);
        cyc(0, 3'b111, 1, 3'b100, 2'b10, 1, 3'b100, 0);
        cyc(0, 3'b111, 1, 3'b000, 2'b11, 0, 3'b000, 0);
        cyc(0, 3'b111, 1, 3'b001, 2'b00, 1, 3'b001, 0);
        cyc(0, 3'b000, 0, 3'b000, 2'b11, 0, 3'b000, 0);
        // Single requester 1. It drops req mid-transaction. Ready arrives in the 2nd BUSY cycle.
        cyc(0, 3'b010, 0, 3'b000, 2'b11, 0, 3'b000, 0);
        cyc(0, 3'b000, 0, 3'b010, 2'b01, 1, 3'b000, 0);
        cyc(0, 3'b000, 1, 3'b010, 2'b01, 1, 3'b010, 0);
        cyc(0, 3'b000, 0, 3'b000, 2'b11, 0, 3'b000, 0);
        // Timeout abort on requester 2. Req changes during BUSY are ignored.
        cyc(0, 3'b100, 0, 3'b000, 2'b11, 0, 3'b000, 0);
        cyc(0, 3'b011, 0, 3'b100, 2'b10, 1, 3'b000, 0);
        cyc(0, 3'b011, 0, 3'b100, 2'b10, 1, 3'b000, 0);
        cyc(0, 3'b011, 0, 3'b100, 2'b10, 1, 3'b000, 0);
        cyc(0, 3'b000, 0, 3'b100, 2'b10, 1, 3'b100, 1);
        cyc(0, 3'b000, 0, 3'b000, 2'b11, 0, 3'b000, 0);
        #2;
        check_eq("last_after_tmo", 8'(dut.last), 8'd2);
        // Ready arrives on the final allowed cycle, so completion wins over the abort.
        cyc(0, 3'b100, 0, 3'b000, 2'b11, 0, 3'b000, 0);
        cyc(0, 3'b100, 0, 3'b100, 2'b10, 1, 3'b000, 0);
        cyc(0, 3'b100, 0, 3'b100, 2'b10, 1, 3'b000, 0);
        cyc(0, 3'b000, 0, 3'b100, 2'b10, 1, 3'b000, 0);
        cyc(0, 3'b000, 1, 3'b100, 2'b10, 1, 3'b100, 0);
        cyc(0, 3'b000, 0, 3'b000, 2'b11, 0, 3'b000, 0);
        // Reset during BUSY drops the transaction. The next grant comes from requester 0.
        cyc(0, 3'b010, 0, 3'b000, 2'b11, 0, 3'b000, 0);
        cyc(1, 3'b010, 1, 3'b010, 2'b01, 1, 3'b000, 0);
        cyc(0, 3'b011, 0, 3'b000, 2'b11, 0, 3'b000, 0);
        cyc(0, 3'b011, 1, 3'b001, 2'b00, 1, 3'b001, 0);
        cyc(0, 3'b000, 0, 3'b000, 2'b11, 0, 3'b000, 0);

        @(negedge clk);
        #2;
        check_eq("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
